// File: rtl/mine_count_scanner.sv
// Sequential 8x8 minefield scanner: snapshots the mine map on start and walks
// one cell per clock, writing neighbour-mine counts (or 4'hF for a mine) and a mine total.
module mine_count_scanner (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [63:0]  mineIn,
  output logic [255:0] countMap,
  output logic [6:0]   mineTotal,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] snap;
  logic [5:0]  idx;
  logic [2:0]  row, col;
  logic        has_up, has_dn, has_lf, has_rt;
  logic [5:0]  i_ul, i_u, i_ur, i_l, i_r, i_dl, i_d, i_dr;
  logic [7:0]  nb;
  logic [3:0]  cnt;
  logic [3:0]  field;

  assign row = idx[5:3];
  assign col = idx[2:0];

  // Edge flags gate each neighbour; the 6-bit offset indices may wrap, but a
  // wrapped index is always masked off by the matching flag.
  assign has_up = (row != 3'd0);
  assign has_dn = (row != 3'd7);
  assign has_lf = (col != 3'd0);
  assign has_rt = (col != 3'd7);

  assign i_ul = idx - 6'd9;
  assign i_u  = idx - 6'd8;
  assign i_ur = idx - 6'd7;
  assign i_l  = idx - 6'd1;
  assign i_r  = idx + 6'd1;
  assign i_dl = idx + 6'd7;
  assign i_d  = idx + 6'd8;
  assign i_dr = idx + 6'd9;

  always_comb begin
    nb    = '0;
    nb[0] = has_up & has_lf & snap[i_ul];
    nb[1] = has_up          & snap[i_u];
    nb[2] = has_up & has_rt & snap[i_ur];
    nb[3] = has_lf          & snap[i_l];
    nb[4] = has_rt          & snap[i_r];
    nb[5] = has_dn & has_lf & snap[i_dl];
    nb[6] = has_dn          & snap[i_d];
    nb[7] = has_dn & has_rt & snap[i_dr];
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, nb[k]};
    end
    field = snap[idx] ? 4'hF : cnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (idx == 6'd63) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      countMap  <= '0;
      mineTotal <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= mineIn;
            countMap  <= '0;
            mineTotal <= '0;
            idx       <= '0;
          end
        end
        SCAN: begin
          countMap[{idx, 2'b00} +: 4] <= field;
          mineTotal <= mineTotal + {6'd0, snap[idx]};
          idx       <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_count_scanner.sv
// Directed self-checking bench for mine_count_scanner; expected maps are hand-built.
module tb_mine_count_scanner;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [63:0]  mineIn;
  logic [255:0] countMap;
  logic [6:0]   mineTotal;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  mine_count_scanner dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .mineIn    (mineIn),
    .countMap  (countMap),
    .mineTotal (mineTotal),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is at a negedge. Pulses start for one edge and observes the scan:
  // lat = edges after the start edge when done is first seen (-1 if never),
  // width = cycles done stayed high, busy_err = cycles busy had the wrong level.
  task automatic run_scan(input logic [63:0] m, output int lat, output int width,
                          output int busy_err);
    mineIn = m;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    width    = 0;
    busy_err = 0;
    if (!busy) busy_err++;
    if (done) width++;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (!busy) busy_err++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat >= 0) begin
      width++;
      @(negedge clk);
      if (done) width++;
      if (busy) busy_err++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    mineIn = '0;
    repeat (2) @(negedge clk);
    total++; if (countMap !== 256'h0) begin bad++; $display("FAIL reset_countMap got=%h want=0", countMap); end
    total++; if (mineTotal !== 7'd0) begin bad++; $display("FAIL reset_mineTotal got=%0d want=0", mineTotal); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat, width, berr;
    run_scan(64'h0, lat, width, berr);
    total++; if (lat !== 64) begin bad++; $display("FAIL empty_latency got=%0d want=64", lat); end
    total++; if (width !== 1) begin bad++; $display("FAIL empty_done_width got=%0d want=1", width); end
    total++; if (berr !== 0) begin bad++; $display("FAIL empty_busy_profile got=%0d bad cycles want=0", berr); end
    total++; if (countMap !== 256'h0) begin bad++; $display("FAIL empty_countMap got=%h want=0", countMap); end
    total++; if (mineTotal !== 7'd0) begin bad++; $display("FAIL empty_mineTotal got=%0d want=0", mineTotal); end
  endtask

  task automatic test_full();
    int lat, width, berr;
    logic [255:0] exp_map;
    exp_map = '1;
    run_scan(64'hFFFF_FFFF_FFFF_FFFF, lat, width, berr);
    total++; if (lat !== 64) begin bad++; $display("FAIL full_latency got=%0d want=64", lat); end
    total++; if (countMap !== exp_map) begin bad++; $display("FAIL full_countMap got=%h want=%h", countMap, exp_map); end
    total++; if (mineTotal !== 7'h40) begin bad++; $display("FAIL full_mineTotal got=%0d want=64", mineTotal); end
  endtask

  task automatic test_corner();
    int lat, width, berr;
    logic [255:0] exp_map;
    exp_map = '0;
    exp_map[0*4 +: 4] = 4'hF;
    exp_map[1*4 +: 4] = 4'h1;
    exp_map[8*4 +: 4] = 4'h1;
    exp_map[9*4 +: 4] = 4'h1;
    run_scan(64'h1, lat, width, berr);
    total++; if (countMap !== exp_map) begin bad++; $display("FAIL corner_countMap got=%h want=%h", countMap, exp_map); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL corner_mineTotal got=%0d want=1", mineTotal); end
  endtask

  task automatic test_centre();
    int lat, width, berr;
    logic [255:0] exp_map;
    exp_map = '0;
    exp_map[27*4 +: 4] = 4'hF;
    exp_map[18*4 +: 4] = 4'h1;
    exp_map[19*4 +: 4] = 4'h1;
    exp_map[20*4 +: 4] = 4'h1;
    exp_map[26*4 +: 4] = 4'h1;
    exp_map[28*4 +: 4] = 4'h1;
    exp_map[34*4 +: 4] = 4'h1;
    exp_map[35*4 +: 4] = 4'h1;
    exp_map[36*4 +: 4] = 4'h1;
    run_scan(64'h0000_0000_0800_0000, lat, width, berr);
    total++; if (countMap !== exp_map) begin bad++; $display("FAIL centre_countMap got=%h want=%h", countMap, exp_map); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL centre_mineTotal got=%0d want=1", mineTotal); end
  endtask

  task automatic test_no_wrap();
    int lat, width, berr;
    logic [255:0] exp_map;
    exp_map = '0;
    exp_map[7*4 +: 4]  = 4'hF;
    exp_map[8*4 +: 4]  = 4'hF;
    exp_map[0*4 +: 4]  = 4'h1;
    exp_map[1*4 +: 4]  = 4'h1;
    exp_map[6*4 +: 4]  = 4'h1;
    exp_map[9*4 +: 4]  = 4'h1;
    exp_map[14*4 +: 4] = 4'h1;
    exp_map[15*4 +: 4] = 4'h1;
    exp_map[16*4 +: 4] = 4'h1;
    exp_map[17*4 +: 4] = 4'h1;
    run_scan(64'h0000_0000_0000_0180, lat, width, berr);
    total++; if (countMap !== exp_map) begin bad++; $display("FAIL nowrap_countMap got=%h want=%h", countMap, exp_map); end
    total++; if (mineTotal !== 7'd2) begin bad++; $display("FAIL nowrap_mineTotal got=%0d want=2", mineTotal); end
  endtask

  // Ring of 8 mines around cell 27: field 27 reaches the maximum count of 8.
  task automatic test_max_count();
    int lat, width, berr;
    run_scan(64'h0000_001C_141C_0000, lat, width, berr);
    total++; if (countMap[27*4 +: 4] !== 4'h8) begin bad++; $display("FAIL ring_field27 got=%h want=8", countMap[27*4 +: 4]); end
    total++; if (countMap[18*4 +: 4] !== 4'hF) begin bad++; $display("FAIL ring_field18 got=%h want=f", countMap[18*4 +: 4]); end
    total++; if (countMap[11*4 +: 4] !== 4'h3) begin bad++; $display("FAIL ring_field11 got=%h want=3", countMap[11*4 +: 4]); end
    total++; if (countMap[29*4 +: 4] !== 4'h3) begin bad++; $display("FAIL ring_field29 got=%h want=3", countMap[29*4 +: 4]); end
    total++; if (countMap[43*4 +: 4] !== 4'h3) begin bad++; $display("FAIL ring_field43 got=%h want=3", countMap[43*4 +: 4]); end
    total++; if (mineTotal !== 7'd8) begin bad++; $display("FAIL ring_mineTotal got=%0d want=8", mineTotal); end
  endtask

  task automatic test_snapshot();
    int dones, lat;
    logic [255:0] exp_map;
    exp_map = '0;
    exp_map[0*4 +: 4] = 4'hF;
    exp_map[1*4 +: 4] = 4'h1;
    exp_map[8*4 +: 4] = 4'h1;
    exp_map[9*4 +: 4] = 4'h1;
    mineIn = 64'h1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    lat   = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (n == 10) begin
        mineIn = 64'hFFFF_0000_FFFF_0000;
        start  = 1'b1;
      end
      if (n == 12) start = 1'b0;
      if (done) begin
        dones++;
        if (lat < 0) lat = n;
      end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL snap_done_count got=%0d want=1", dones); end
    total++; if (lat !== 64) begin bad++; $display("FAIL snap_latency got=%0d want=64", lat); end
    total++; if (countMap !== exp_map) begin bad++; $display("FAIL snap_countMap got=%h want=%h", countMap, exp_map); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL snap_mineTotal got=%0d want=1", mineTotal); end
  endtask

  // Start held only during the done cycle is dropped; results then hold in IDLE.
  task automatic test_start_in_done();
    int lat, busy_seen;
    mineIn = 64'h0000_0000_0800_0000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    mineIn = 64'h0;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busy_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++; if (lat !== 64) begin bad++; $display("FAIL sdone_latency got=%0d want=64", lat); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL sdone_ignored got=%0d busy cycles want=0", busy_seen); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL sdone_hold_total got=%0d want=1", mineTotal); end
    total++; if (countMap[27*4 +: 4] !== 4'hF) begin bad++; $display("FAIL sdone_hold_field got=%h want=f", countMap[27*4 +: 4]); end
  endtask

  task automatic test_back_to_back();
    int lat1, w1, b1, lat2, w2, b2;
    run_scan(64'hFFFF_FFFF_FFFF_FFFF, lat1, w1, b1);
    run_scan(64'h1, lat2, w2, b2);
    total++; if (lat2 !== 64) begin bad++; $display("FAIL b2b_latency got=%0d want=64", lat2); end
    total++; if (b2 !== 0) begin bad++; $display("FAIL b2b_busy_profile got=%0d want=0", b2); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL b2b_mineTotal got=%0d want=1", mineTotal); end
    total++; if (countMap[2*4 +: 4] !== 4'h0) begin bad++; $display("FAIL b2b_field2 got=%h want=0", countMap[2*4 +: 4]); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, width, berr;
    mineIn = 64'hFFFF_FFFF_FFFF_FFFF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    total++; if (countMap !== 256'h0) begin bad++; $display("FAIL midrst_countMap got=%h want=0", countMap); end
    total++; if (mineTotal !== 7'd0) begin bad++; $display("FAIL midrst_mineTotal got=%0d want=0", mineTotal); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    run_scan(64'h0000_0000_0800_0000, lat, width, berr);
    total++; if (lat !== 64) begin bad++; $display("FAIL midrst_rescan_latency got=%0d want=64", lat); end
    total++; if (width !== 1) begin bad++; $display("FAIL midrst_rescan_width got=%0d want=1", width); end
    total++; if (mineTotal !== 7'd1) begin bad++; $display("FAIL midrst_rescan_total got=%0d want=1", mineTotal); end
    total++; if (countMap[35*4 +: 4] !== 4'h1) begin bad++; $display("FAIL midrst_rescan_field35 got=%h want=1", countMap[35*4 +: 4]); end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    mineIn = '0;
    @(negedge clk);
    test_reset();
    test_empty();
    test_full();
    test_corner();
    test_centre();
    test_no_wrap();
    test_max_count();
    test_snapshot();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
